// File: rtl/mips_defs.sv
// Shared MIPS definitions: multiply/divide op encodings, default latencies,
// controller state encoding and the 64-bit HI/LO result payload.
package mips_defs;

  localparam int unsigned XLEN            = 32;
  localparam int unsigned OP_W            = 3;
  localparam int unsigned CNT_W           = 4;
  localparam int unsigned MULT_CYCLES_DEF = 5;
  localparam int unsigned DIV_CYCLES_DEF  = 10;

  localparam logic [OP_W-1:0] MD_OP_MULT  = 3'd0;
  localparam logic [OP_W-1:0] MD_OP_MULTU = 3'd1;
  localparam logic [OP_W-1:0] MD_OP_DIV   = 3'd2;
  localparam logic [OP_W-1:0] MD_OP_DIVU  = 3'd3;
  localparam logic [OP_W-1:0] MD_OP_MTHI  = 3'd4;
  localparam logic [OP_W-1:0] MD_OP_MTLO  = 3'd5;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } md_state_e;

  typedef struct packed {
    logic [XLEN-1:0] hi;
    logic [XLEN-1:0] lo;
  } md_res_t;

  // MULT/MULTU/DIV/DIVU occupy the unit; MTHI/MTLO and no-ops do not.
  function automatic logic is_arith_op(input logic [OP_W-1:0] op);
    return (op[2] == 1'b0);
  endfunction

endpackage

// File: rtl/md_arith.sv
// Combinational multiply/divide datapath producing the {hi, lo} result
// and a divide-by-zero flag for the controller.
module md_arith
  import mips_defs::*;
(
  input  logic [OP_W-1:0] op,
  input  logic [XLEN-1:0] src_a,
  input  logic [XLEN-1:0] src_b,
  output md_res_t         res,
  output logic            div_by_zero
);

  logic signed [2*XLEN-1:0] sa_ext;
  logic signed [2*XLEN-1:0] sb_ext;
  logic        [2*XLEN-1:0] ua_ext;
  logic        [2*XLEN-1:0] ub_ext;
  logic signed [XLEN-1:0]   sa;
  logic signed [XLEN-1:0]   sb;

  assign sa     = $signed(src_a);
  assign sb     = $signed(src_b);
  assign sa_ext = $signed({{XLEN{src_a[XLEN-1]}}, src_a});
  assign sb_ext = $signed({{XLEN{src_b[XLEN-1]}}, src_b});
  assign ua_ext = {XLEN'(0), src_a};
  assign ub_ext = {XLEN'(0), src_b};

  // Overflow and zero-divisor cases are resolved explicitly, never left to the operator.
  always_comb begin
    res         = '0;
    div_by_zero = 1'b0;
    case (op)
      MD_OP_MULT:  res = md_res_t'(sa_ext * sb_ext);
      MD_OP_MULTU: res = md_res_t'(ua_ext * ub_ext);
      MD_OP_DIV: begin
        if (src_b == '0) begin
          div_by_zero = 1'b1;
        end else if (src_a == 32'h8000_0000 && src_b == 32'hFFFF_FFFF) begin
          res.lo = 32'h8000_0000;
          res.hi = '0;
        end else begin
          res.lo = XLEN'(sa / sb);
          res.hi = XLEN'(sa % sb);
        end
      end
      MD_OP_DIVU: begin
        if (src_b == '0) begin
          div_by_zero = 1'b1;
        end else begin
          res.lo = src_a / src_b;
          res.hi = src_a % src_b;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/muldiv_ctrl.sv
// Multi-cycle multiply/divide controller: fixed-latency busy window, HI/LO
// commit, MTHI/MTLO writes and the D-stage stall for md-class instructions.
module muldiv_ctrl
  import mips_defs::*;
#(
  parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            md_start,
  input  logic [OP_W-1:0] md_op,
  input  logic [XLEN-1:0] src_a,
  input  logic [XLEN-1:0] src_b,
  input  logic            md_use_D,
  output logic            busy,
  output logic            md_stall,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo
);

  md_state_e        state;
  md_state_e        state_n;
  logic [CNT_W-1:0] cnt;
  logic [XLEN-1:0]  hi_n;
  logic [XLEN-1:0]  lo_n;
  logic             dz_q;
  logic             done_c;
  logic             launch_c;
  md_res_t          arith_res;
  logic             arith_dz;

  md_arith u_arith (
    .op          (md_op),
    .src_a       (src_a),
    .src_b       (src_b),
    .res         (arith_res),
    .div_by_zero (arith_dz)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_n;
  end

  // Starts are only honoured from IDLE; a start presented while running is dropped.
  always_comb begin
    state_n = state;
    case (state)
      ST_IDLE: if (launch_c) state_n = ST_RUN;
      ST_RUN:  if (done_c)   state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase
  end

  always_comb begin
    busy     = 1'b0;
    done_c   = 1'b0;
    launch_c = 1'b0;
    md_stall = 1'b0;
    busy     = (state == ST_RUN);
    done_c   = busy && (cnt <= CNT_W'(1));
    launch_c = !busy && md_start && is_arith_op(md_op);
    md_stall = md_use_D && (md_start || busy);
  end

  // Shadow result is captured at launch and copied to HI/LO on the last busy cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt  <= '0;
      hi   <= '0;
      lo   <= '0;
      hi_n <= '0;
      lo_n <= '0;
      dz_q <= 1'b0;
    end else if (state == ST_IDLE) begin
      if (launch_c) begin
        hi_n <= arith_res.hi;
        lo_n <= arith_res.lo;
        dz_q <= arith_dz;
        cnt  <= CNT_W'(md_op[1] ? DIV_CYCLES : MULT_CYCLES);
      end else if (md_start && md_op == MD_OP_MTHI) begin
        hi <= src_a;
      end else if (md_start && md_op == MD_OP_MTLO) begin
        lo <= src_a;
      end
    end else begin
      cnt <= cnt - CNT_W'(1);
      if (done_c && !dz_q) begin
        hi <= hi_n;
        lo <= lo_n;
      end
    end
  end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Self-checking bench for muldiv_ctrl: vector table of mult/div ops plus
// hand sequences for stall, back-to-back, mid-run reset and ignored starts.
module tb_muldiv_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        md_start;
  logic [2:0]  md_op;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        md_use_D;
  logic        busy;
  logic        md_stall;
  logic [31:0] hi;
  logic [31:0] lo;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] pre_hi;
    logic [31:0] pre_lo;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
    int          n;
  } vec_t;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
  } exp_t;

  vec_t vecs[10];
  exp_t sb_q[$];

  muldiv_ctrl dut (
    .clk      (clk),
    .reset    (reset),
    .md_start (md_start),
    .md_op    (md_op),
    .src_a    (src_a),
    .src_b    (src_b),
    .md_use_D (md_use_D),
    .busy     (busy),
    .md_stall (md_stall),
    .hi       (hi),
    .lo       (lo)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got running expected finished");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // MTHI/MTLO: value must be visible in the following cycle without busy.
  task automatic mt(input logic [2:0] op, input logic [31:0] val);
    md_start = 1'b1;
    md_op    = op;
    src_a    = val;
    step();
    md_start = 1'b0;
    check("mt_busy", 32'(busy), 32'd0);
    if (op == 3'd4) check("mthi", hi, val);
    else            check("mtlo", lo, val);
  endtask

  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_hi, input logic [31:0] exp_lo, input int n,
                        input bit use_d, input bit intrude, input string tag);
    exp_t e;
    exp_t got;
    int   bcnt;
    md_start = 1'b1;
    md_op    = op;
    src_a    = a;
    src_b    = b;
    md_use_D = use_d;
    #1;
    if (use_d) check({tag, "_stall_start"}, 32'(md_stall), 32'd1);
    e.hi = exp_hi;
    e.lo = exp_lo;
    sb_q.push_back(e);
    step();
    md_start = 1'b0;
    src_a    = 32'hA5A5_A5A5;
    src_b    = 32'h5A5A_5A5A;
    bcnt     = 0;
    while (busy && bcnt < 40) begin
      bcnt++;
      if (use_d) check({tag, "_stall_busy"}, 32'(md_stall), 32'd1);
      if (intrude) begin
        if (bcnt == 2) begin md_start = 1'b1; md_op = 3'd5; src_a = 32'h0000_DEAD; end
        if (bcnt == 3) begin md_op = 3'd2; src_a = 32'd9; src_b = 32'd0; end
        if (bcnt == 4) md_start = 1'b0;
      end
      step();
    end
    md_start = 1'b0;
    check({tag, "_busy_len"}, 32'(bcnt), 32'(n));
    if (use_d) begin
      #1;
      check({tag, "_stall_after"}, 32'(md_stall), 32'd0);
    end
    if (sb_q.size() == 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s_scoreboard: got empty queue expected entry", tag);
    end else begin
      got = sb_q.pop_front();
      check({tag, "_hi"}, hi, got.hi);
      check({tag, "_lo"}, lo, got.lo);
    end
  endtask

  initial begin
    vecs[0] = '{3'd0, 32'hFFFF_FFFF, 32'h2,        32'h0,  32'h0,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 5};
    vecs[1] = '{3'd1, 32'hFFFF_FFFF, 32'h2,        32'h0,  32'h0,  32'h0000_0001, 32'hFFFF_FFFE, 5};
    vecs[2] = '{3'd2, 32'hFFFF_FFF9, 32'h2,        32'h5,  32'h6,  32'hFFFF_FFFF, 32'hFFFF_FFFD, 10};
    vecs[3] = '{3'd3, 32'h7,         32'h2,        32'h5,  32'h6,  32'h1,         32'h3,         10};
    vecs[4] = '{3'd2, 32'h1234,      32'h0,        32'h11, 32'h22, 32'h11,        32'h22,        10};
    vecs[5] = '{3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h7, 32'h8,  32'h0,         32'h8000_0000, 10};
    vecs[6] = '{3'd0, 32'h8000_0000, 32'h8000_0000, 32'h1, 32'h1,  32'h4000_0000, 32'h0,         5};
    vecs[7] = '{3'd1, 32'h8000_0000, 32'h2,        32'h1,  32'h1,  32'h1,         32'h0,         5};
    vecs[8] = '{3'd3, 32'hFFFF_FFFF, 32'h10,       32'h9,  32'h9,  32'hF,         32'h0FFF_FFFF, 10};
    vecs[9] = '{3'd3, 32'hCAFE,      32'h0,        32'h33, 32'h44, 32'h33,        32'h44,        10};

    reset    = 1'b1;
    md_start = 1'b0;
    md_op    = 3'd0;
    src_a    = '0;
    src_b    = '0;
    md_use_D = 1'b0;
    repeat (3) step();
    check("rst_busy",  32'(busy), 32'd0);
    check("rst_stall", 32'(md_stall), 32'd0);
    check("rst_hi",    hi, 32'd0);
    check("rst_lo",    lo, 32'd0);
    reset = 1'b0;
    step();

    foreach (vecs[i]) begin
      mt(3'd4, vecs[i].pre_hi);
      mt(3'd5, vecs[i].pre_lo);
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp_hi, vecs[i].exp_lo,
             vecs[i].n, 1'b0, 1'b0, $sformatf("vec%0d", i));
    end

    // Stall held through a MULT, then a second MULT started in T+6.
    run_op(3'd0, 32'd6, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEE, 5, 1'b1, 1'b0, "stall1");
    run_op(3'd1, 32'd100, 32'd7, 32'd0, 32'd700, 5, 1'b1, 1'b0, "b2b");
    md_use_D = 1'b0;
    #1;
    check("stall_idle", 32'(md_stall), 32'd0);

    // Starts presented while busy are dropped.
    run_op(3'd1, 32'd3, 32'd5, 32'd0, 32'd15, 5, 1'b0, 1'b1, "intrude");
    repeat (12) step();
    check("intrude_settle_hi", hi, 32'd0);
    check("intrude_settle_lo", lo, 32'd15);
    check("intrude_settle_busy", 32'(busy), 32'd0);

    // Reset during busy cycle 3 of a DIV aborts it with no later commit.
    mt(3'd4, 32'h77);
    mt(3'd5, 32'h88);
    md_start = 1'b1;
    md_op    = 3'd3;
    src_a    = 32'd7;
    src_b    = 32'd2;
    step();
    md_start = 1'b0;
    check("abort_busy_c1", 32'(busy), 32'd1);
    step();
    step();
    check("abort_busy_c3", 32'(busy), 32'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_hi", hi, 32'd0);
    check("abort_lo", lo, 32'd0);
    repeat (12) step();
    check("abort_late_hi", hi, 32'd0);
    check("abort_late_lo", lo, 32'd0);
    check("abort_late_busy", 32'(busy), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
